fetch_sequencer: RTL
====================

# fetch_sequencer

Front-end sequencer sitting on the other side of the `pc` register: consumes the current `pc`, fetches the instruction word at that address over a req/ack memory handshake, hands it to the decoder over a valid/ready handshake, and drives `next_pc` back into `pc`. Because `pc` loads `next_pc` on every rising edge and has no enable or reset, this block owns all PC sequencing: hold, increment, branch and reset vector.

## Interface

- `BITS`, 8, datapath/address width
- `RESET_PC`, 0, address `pc` is forced to during reset
- `clk`  in  1  rising-edge clock, shared with `pc`
- `rst`  in  1  synchronous, active-high reset
- `pc`  in  BITS  current program counter from `pc`
- `next_pc`  out  BITS  value `pc` loads on the next edge; combinational
- `mem_req`  out  1  instruction read request
- `mem_addr`  out  BITS  read address; equals `pc` whenever `mem_req`=1
- `mem_ack`  in  1  memory returns `mem_data` this cycle
- `mem_data`  in  BITS  instruction word, valid only with `mem_ack`
- `instr`  out  BITS  registered instruction for the decoder
- `instr_valid`  out  1  `instr` holds an unconsumed instruction
- `instr_ready`  in  1  decoder accepts `instr` this cycle
- `branch_taken`  in  1  redirect on acceptance
- `branch_target`  in  BITS  redirect address
- `fetch_count`  out  BITS  instructions accepted since reset, wraps

## Operation

- Two-state FSM: FETCH, HOLD. Reset state FETCH.
- FETCH: `mem_req`=1, `mem_addr`=`pc`, `instr_valid`=0. On `mem_ack`: `instr` <= `mem_data`, go to HOLD. Without ack: stay, request held stable.
- HOLD: `mem_req`=0, `instr_valid`=1, `instr` stable. On `instr_ready` (acceptance): go to FETCH, `fetch_count` += 1. Without ready: stay.
- `next_pc` (combinational, priority order):
  - `rst`=1 -> `RESET_PC`
  - HOLD and `instr_ready`=1 -> `branch_taken` ? `branch_target` : `pc`+1
  - otherwise -> `pc` (hold)
- `pc`+1 is modulo 2^BITS: `pc`=2^BITS-1 -> `next_pc`=0. `fetch_count` also wraps to 0.
- `branch_taken`/`branch_target` sampled only on the acceptance cycle; ignored otherwise.
- `mem_ack` in HOLD or during reset is ignored; `mem_data` never captured outside FETCH.
- `instr_ready` in FETCH is ignored (no acceptance without valid).

## Timing

- During any cycle with `rst`=1: `mem_req`=0, `instr_valid`=0, `next_pc`=`RESET_PC`; registers `instr`=0, `fetch_count`=0, state=FETCH at the edge.
- `rst` must be high for at least one rising edge; first cycle after deassertion `pc`=`RESET_PC` and `mem_req`=1.
- Reset mid-operation (either state, including the ack or acceptance cycle): reset wins; no capture, no count, `next_pc`=`RESET_PC`.
- Best-case throughput: ack in first FETCH cycle, ready in first HOLD cycle -> one instruction every 2 cycles; `pc` updates at the acceptance edge, new `mem_addr` visible the following cycle.
- `mem_addr` and `pc` never change while `mem_req`=1 and no ack has arrived.
- `instr` and `instr_valid` change only on clock edges; `next_pc` combinational from `pc`, state, `rst`, `instr_ready`, `branch_*`.

## Test plan

- Reset: `rst`=1 two cycles, RESET_PC=0x10 -> `next_pc`=0x10, `mem_req`=0, `instr_valid`=0, `fetch_count`=0; after release `pc`=0x10, `mem_addr`=0x10, `mem_req`=1.
- Sequential stream: ack every FETCH cycle, ready always high, memory returns address XOR 0xA5 -> `pc` steps 0x00,0x01,0x02... one per 2 cycles, each `instr`=pc^0xA5, `fetch_count` increments by 1 per acceptance.
- Stalls: ack delayed 3 cycles, then ready delayed 2 cycles -> `next_pc`=`pc` and `mem_addr` stable throughout, `instr` stable in HOLD, exactly one count increment.
- Branch: accept at `pc`=0x05 with `branch_taken`=1, target 0x40 -> next fetch address 0x40; `branch_taken`=1 asserted in FETCH has no effect.
- Wrap: run from `pc`=0xFE with ready/ack always high -> `pc` 0xFE,0xFF,0x00; `fetch_count` wraps 0xFF->0x00 after 256 acceptances.
- Reset mid-HOLD with `instr_ready`=1 and `branch_taken`=1 -> `next_pc`=`RESET_PC`, no count, `instr_valid`=0 next cycle, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Front-end sequencer that owns all PC sequencing for an external `pc`
// register (which loads `next_pc` unconditionally on every rising edge).
// It fetches the instruction at `pc` over a req/ack memory handshake, holds
// it for the decoder behind a valid/ready handshake, and then advances the
// PC: increment, branch redirect, hold, or reset vector.
//
// Parameters
//   BITS          datapath / address width
//   RESET_PC      address driven onto next_pc while rst is high
//
// Ports
//   clk           rising-edge clock, shared with the pc register
//   rst           synchronous, active-high reset
//   pc            current program counter
//   next_pc       value pc loads on the next edge (combinational)
//   mem_req       instruction read request (FETCH state)
//   mem_addr      read address, always equal to pc
//   mem_ack       memory returns mem_data this cycle
//   mem_data      instruction word, valid only with mem_ack
//   instr         registered instruction for the decoder
//   instr_valid   instr holds an unconsumed instruction (HOLD state)
//   instr_ready   decoder accepts instr this cycle
//   branch_taken  redirect on acceptance
//   branch_target redirect address
//   fetch_count   instructions accepted since reset, wraps modulo 2^BITS
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                BITS     = 8,
    parameter logic [BITS-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] pc,
    output logic [BITS-1:0] next_pc,
    output logic            mem_req,
    output logic [BITS-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [BITS-1:0] mem_data,
    output logic [BITS-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            branch_taken,
    input  logic [BITS-1:0] branch_target,
    output logic [BITS-1:0] fetch_count
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state;

    // Modulo-2^BITS increment; the carry out of the top bit is dropped so
    // the all-ones address rolls over to zero.
    function automatic logic [BITS-1:0] wrap_inc(input logic [BITS-1:0] v);
        logic [BITS:0] sum;
        sum      = {1'b0, v} + {{BITS{1'b0}}, 1'b1};
        wrap_inc = sum[BITS-1:0];
    endfunction

    logic accept;
    assign accept = (state == HOLD) && instr_ready;

    // Control, instruction capture and acceptance counter. Reset overrides
    // any ack or acceptance arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            instr       <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr <= mem_data;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        fetch_count <= wrap_inc(fetch_count);
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // The handshake outputs are decoded from the registered state; rst masks
    // them so that a reset cycle never shows a request or a valid word.
    assign mem_req     = (state == FETCH) && !rst;
    assign instr_valid = (state == HOLD)  && !rst;

    // pc only moves on acceptance, so the address presented while a request
    // is outstanding is stable by construction.
    assign mem_addr = pc;

    always_comb begin
        next_pc = pc;
        if (rst) begin
            next_pc = RESET_PC;
        end else if (accept) begin
            next_pc = branch_taken ? branch_target : wrap_inc(pc);
        end
    end

endmodule
